ff_bank_arbiter: RTL and testbench
==================================

// Module: ff_bank_arbiter
// PURPOSE
//   Owns a WIDTH-bit flip-flop register bank q and shares write access between two requesters.
//   Requester D loads a full word (D-flip-flop mode). Requester T toggles masked bits (T-flip-flop mode).
//   A round-robin FSM grants one operation at a time and sequences the bank enable.
//   An optional inter-operation gap is enforced after each operation.
//   Sits between the flip-flop bank and the control logic that issues load/toggle commands.
// PARAMETERS
//   WIDTH  8  bank width in bits (>=1)
//   GAP    0  idle cycles enforced after each committed op (0..15)
// PORTS
//   clk      in   1      rising-edge clock, single clock domain
//   reset    in   1      synchronous, active-high reset
//   d_req    in   1      load request; hold with d_data stable until d_ack
//   d_data   in   WIDTH  word to load
//   d_ack    out  1      1-cycle pulse: load committing this cycle
//   t_req    in   1      toggle request; hold with t_mask stable until t_ack
//   t_mask   in   WIDTH  bits to invert
//   t_ack    out  1      1-cycle pulse: toggle committing this cycle
//   q        out  WIDTH  bank contents (registered)
//   busy     out  1      high in any state other than IDLE
//   last_src out  1      source of last committed op (0=D, 1=T)
// BEHAVIOUR
//   Reset: all values are reset-synchronous; reset has priority over every other event on the same edge.
//     q=0, d_ack=0, t_ack=0, busy=0, last_src=0, state=IDLE, ptr=0 (D favoured), gap_cnt=0.
//   FSM states: IDLE, SERVE_D, SERVE_T, HOLD.
//   IDLE transitions:
//     - d_req only -> SERVE_D.
//     - t_req only -> SERVE_T.
//     - Both requests -> SERVE_D if ptr=0, else SERVE_T.
//     - Neither request -> stay in IDLE.
//   SERVE_x (exactly 1 cycle):
//     - x_ack=1 (decoded from state).
//     - At the closing edge: q<=d_data (D) or q<=q^t_mask (T); last_src<=x; ptr<=opposite of x.
//     - Next state: HOLD with gap_cnt<=GAP-1 if GAP>0, else IDLE.
//   HOLD: gap_cnt decrements each cycle; at 0 -> IDLE. Requests are ignored in HOLD.
//   Latency: request seen in IDLE at edge k; ack high in cycle k..k+1; new q visible after edge k+1.
//   Throughput: one op per (2+GAP) cycles when a request is held continuously.
//   Handshake: requester samples ack at the edge and drops req (or presents the next op) in the following cycle.
//     A request still high in IDLE is served again (back-to-back).
//   Boundaries:
//     - Request dropped during SERVE_x: op still commits (grant is final).
//     - t_mask=0: ack issued, q unchanged.
//     - Reset in SERVE_x: no commit; q=0.
//     - Reset in HOLD: gap aborted.
//     - Width arithmetic: XOR only, no carries; q never holds X after reset.
// CONFIGURATION
//   FF_BANK_CLR_EN defined:
//     - Adds clr_req (in, 1) and clr_ack (out, 1) and a SERVE_C state.
//     - In IDLE, clr_req wins over d_req/t_req.
//     - SERVE_C: clr_ack=1; q<=0 at the closing edge; ptr and last_src unchanged; GAP applies.
//   FF_BANK_CLR_EN undefined: clr ports and SERVE_C are absent; arbitration is D/T only.
// TESTING (WIDTH=8)
//   1. Reset: assert reset 2 cycles with d_req=t_req=1 -> q=0x00, acks 0, busy 0 throughout.
//   2. GAP=0, d_req=1, d_data=0xA5:
//      -> d_ack pulses exactly 1 cycle; q=0xA5 from the next cycle; last_src=0.
//   3. q=0xA5, t_req=1, t_mask=0x0F -> t_ack 1 cycle; q=0xAA; last_src=1.
//      Then t_mask=0x00 -> t_ack pulses, q stays 0xAA.
//   4. From reset, both reqs held, d_data=0x3C, t_mask=0xFF:
//      -> grants alternate D,T,D; q sequence 0x3C,0xC3,0x3C.
//      With GAP=2: exactly 2 busy idle cycles between ack pulses.
//   5. Assert reset during SERVE_D (d_data=0x55, q=0x12):
//      -> no d_ack after reset; q=0x00; state IDLE next cycle.
//   6. FF_BANK_CLR_EN, q=0x5A, clr_req and d_req (0x77) together:
//      -> clr_ack first, q=0x00; then d_ack, q=0x77.

Source files
------------

// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter: a WIDTH-bit register bank q with shared write access.
//   Requester D loads a full word. Requester T inverts the bits set in t_mask.
//   A round-robin FSM grants one operation at a time. Each granted operation
//   spends exactly one SERVE cycle, commits at that cycle's closing edge, and
//   is then followed by GAP enforced idle cycles in HOLD.
// Optional feature macro: FF_BANK_CLR_EN adds a clear requester
//   (clr_req / clr_ack, state SERVE_C) that wins arbitration in IDLE.
// Reset is synchronous and active-high, and it overrides every other event.
module ff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_req,
  input  logic [WIDTH-1:0] d_data,
  output logic             d_ack,
  input  logic             t_req,
  input  logic [WIDTH-1:0] t_mask,
  output logic             t_ack,
`ifdef FF_BANK_CLR_EN
  input  logic             clr_req,
  output logic             clr_ack,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             last_src
);

  // Load value for the gap counter. HOLD runs while the counter counts down
  // to zero, so GAP-1 gives exactly GAP cycles in HOLD.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE_D = 3'd1,
    ST_SERVE_T = 3'd2,
`ifdef FF_BANK_CLR_EN
    ST_SERVE_C = 3'd4,
`endif
    ST_HOLD    = 3'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_q;
  logic             r_last_src;
  logic             r_ptr;      // 0: D wins a tie, 1: T wins a tie
  logic [3:0]       r_gap_cnt;

  // State register. Reset returns the FSM to IDLE from any state, which
  // drops a pending commit and aborts a gap.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the values from before the edge, whatever the block order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: arbitration in IDLE, the fixed one-cycle SERVE, then HOLD.
  always_comb begin
    // NOTE: the default comes first, so every path assigns w_next and no
    // latch is inferred.
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
`ifdef FF_BANK_CLR_EN
        if (clr_req) w_next = ST_SERVE_C;
        else
`endif
        if (d_req && t_req) w_next = r_ptr ? ST_SERVE_T : ST_SERVE_D;
        else if (d_req)     w_next = ST_SERVE_D;
        else if (t_req)     w_next = ST_SERVE_T;
        else                w_next = ST_IDLE;
      end
`ifdef FF_BANK_CLR_EN
      ST_SERVE_C,
`endif
      ST_SERVE_D,
      ST_SERVE_T: begin
        w_next = (GAP > 0) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        // Requests are not looked at here. They wait until IDLE.
        if (r_gap_cnt == 4'd0) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bank datapath: commit the granted operation at the closing edge of SERVE
  // and run the gap counter. The grant is final, so the request inputs are
  // not checked here again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= '0;
      r_last_src <= 1'b0;
      r_ptr      <= 1'b0;
      r_gap_cnt  <= 4'd0;
    end else begin
      unique case (r_state)
        ST_SERVE_D: begin
          r_q        <= d_data;
          r_last_src <= 1'b0;
          r_ptr      <= 1'b1;
          r_gap_cnt  <= GAP_LOAD;
        end
        ST_SERVE_T: begin
          r_q        <= r_q ^ t_mask;
          r_last_src <= 1'b1;
          r_ptr      <= 1'b0;
          r_gap_cnt  <= GAP_LOAD;
        end
`ifdef FF_BANK_CLR_EN
        ST_SERVE_C: begin
          // A clear does not change fairness between D and T.
          r_q       <= '0;
          r_gap_cnt <= GAP_LOAD;
        end
`endif
        ST_HOLD: begin
          if (r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // The acks and busy are decoded from the registered state, so each ack is
  // high for exactly the one SERVE cycle.
  assign d_ack    = (r_state == ST_SERVE_D);
  assign t_ack    = (r_state == ST_SERVE_T);
`ifdef FF_BANK_CLR_EN
  assign clr_ack  = (r_state == ST_SERVE_C);
`endif
  assign busy     = (r_state != ST_IDLE);
  assign q        = r_q;
  assign last_src = r_last_src;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter (WIDTH=8). It uses two instances: u0 with GAP=0
// and u1 with GAP=2, each with its own requesters and a shared reset.
// An operation-level model predicts q, the acks, busy and last_src, and a
// compare process checks every negedge after the first reset. Directed steps
// also check hand-computed literal values.
module tb_ff_bank_arbiter;

  localparam int W = 8;
  localparam int GAPS [2] = '{0, 2};

  logic         clk = 1'b0;
  logic         reset;
  logic         d_req   [2];
  logic [W-1:0] d_data  [2];
  logic         t_req   [2];
  logic [W-1:0] t_mask  [2];
  logic         clr_req [2];
  logic         d_ack   [2];
  logic         t_ack   [2];
  logic         clr_ack [2];
  logic [W-1:0] q       [2];
  logic         busy    [2];
  logic         last_src[2];

  always #5 clk = ~clk;

  ff_bank_arbiter #(.WIDTH(W), .GAP(0)) u0 (
    .clk(clk), .reset(reset),
    .d_req(d_req[0]), .d_data(d_data[0]), .d_ack(d_ack[0]),
    .t_req(t_req[0]), .t_mask(t_mask[0]), .t_ack(t_ack[0]),
`ifdef FF_BANK_CLR_EN
    .clr_req(clr_req[0]), .clr_ack(clr_ack[0]),
`endif
    .q(q[0]), .busy(busy[0]), .last_src(last_src[0])
  );

  ff_bank_arbiter #(.WIDTH(W), .GAP(2)) u1 (
    .clk(clk), .reset(reset),
    .d_req(d_req[1]), .d_data(d_data[1]), .d_ack(d_ack[1]),
    .t_req(t_req[1]), .t_mask(t_mask[1]), .t_ack(t_ack[1]),
`ifdef FF_BANK_CLR_EN
    .clr_req(clr_req[1]), .clr_ack(clr_ack[1]),
`endif
    .q(q[1]), .busy(busy[1]), .last_src(last_src[1])
  );

`ifndef FF_BANK_CLR_EN
  assign clr_ack[0] = 1'b0;
  assign clr_ack[1] = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model. m_op is the operation being served this cycle
  // (0 none, 1 load, 2 toggle, 3 clear). m_hold counts the enforced idle
  // cycles still left.
  logic [W-1:0] m_q    [2];
  int           m_op   [2];
  int           m_hold [2];
  bit           m_ptr  [2];
  bit           m_last [2];
  bit           m_valid = 0;

  task automatic model_step(input int i);
    if (reset) begin
      m_q[i] = '0; m_op[i] = 0; m_hold[i] = 0; m_ptr[i] = 0; m_last[i] = 0;
    end else if (m_op[i] != 0) begin
      case (m_op[i])
        1: begin m_q[i] = d_data[i];           m_last[i] = 0; m_ptr[i] = 1; end
        2: begin m_q[i] = m_q[i] ^ t_mask[i];  m_last[i] = 1; m_ptr[i] = 0; end
        default: m_q[i] = '0;
      endcase
      m_op[i]   = 0;
      m_hold[i] = GAPS[i];
    end else if (m_hold[i] > 0) begin
      m_hold[i]--;
    end else begin
`ifdef FF_BANK_CLR_EN
      if (clr_req[i]) m_op[i] = 3;
      else
`endif
      if (d_req[i] && t_req[i]) m_op[i] = m_ptr[i] ? 2 : 1;
      else if (d_req[i])        m_op[i] = 1;
      else if (t_req[i])        m_op[i] = 2;
    end
  endtask

  // Advance one clock. Inputs change 2 time units after the edge, and the
  // model steps at the edge using the inputs from before it.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (reset) m_valid = 1;
    #2;
  endtask

  // Compare process: check both instances against the model on every negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("u%0d.q", i),        32'(q[i]),        32'(m_q[i]));
          check($sformatf("u%0d.d_ack", i),    32'(d_ack[i]),    32'(m_op[i] == 1));
          check($sformatf("u%0d.t_ack", i),    32'(t_ack[i]),    32'(m_op[i] == 2));
          check($sformatf("u%0d.clr_ack", i),  32'(clr_ack[i]),  32'(m_op[i] == 3));
          check($sformatf("u%0d.busy", i),     32'(busy[i]),     32'(m_op[i] != 0 || m_hold[i] > 0));
          check($sformatf("u%0d.last_src", i), 32'(last_src[i]), 32'(m_last[i]));
        end
      end
    end
  end

  // Table for the held-request run: bit n-1 gives the value after tick n.
  logic [8:0] e0_dack = 9'b1_0001_0001; // u0 D grants at ticks 1,5,9
  logic [8:0] e0_tack = 9'b0_0100_0100; // u0 T grants at ticks 3,7
  logic [8:0] e1_dack = 9'b1_0000_0001; // u1 D grants at ticks 1,9
  logic [8:0] e1_tack = 9'b0_0001_0000; // u1 T grant at tick 5
  logic [8:0] e1_busy = 9'b1_0111_0111; // u1 busy, idle at ticks 4,8

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_req[i] = 0; t_req[i] = 0; clr_req[i] = 0; d_data[i] = '0; t_mask[i] = '0;
    end
    // 1. Reset for 2 cycles with both requests high.
    reset = 1;
    d_req[0] = 1; t_req[0] = 1; d_data[0] = 8'hA5; t_mask[0] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst.q", 32'(q[0]), 32'h00);
      check("rst.acks", 32'({d_ack[0], t_ack[0]}), 32'h0);
      check("rst.busy", 32'(busy[0]), 32'h0);
    end
    reset = 0; d_req[0] = 0; t_req[0] = 0;
    tick();

    // 2. Load 0xA5.
    d_req[0] = 1; d_data[0] = 8'hA5;
    tick();
    check("ld.ack", 32'(d_ack[0]), 32'h1);
    check("ld.q_before", 32'(q[0]), 32'h00);
    tick();
    check("ld.ack_end", 32'(d_ack[0]), 32'h0);
    check("ld.q", 32'(q[0]), 32'hA5);
    check("ld.last", 32'(last_src[0]), 32'h0);
    d_req[0] = 0;
    tick();

    // 3. Toggle 0x0F, then a zero mask that is presented right away.
    t_req[0] = 1; t_mask[0] = 8'h0F;
    tick();
    check("tg.ack", 32'(t_ack[0]), 32'h1);
    tick();
    check("tg.q", 32'(q[0]), 32'hAA);
    check("tg.last", 32'(last_src[0]), 32'h1);
    t_mask[0] = 8'h00;
    tick();
    check("tg0.ack", 32'(t_ack[0]), 32'h1);
    tick();
    check("tg0.q", 32'(q[0]), 32'hAA);
    t_req[0] = 0;
    tick();

    // The request is dropped during SERVE, and the load still commits.
    d_req[0] = 1; d_data[0] = 8'h81;
    tick();
    d_req[0] = 0;
    tick();
    check("drop.q", 32'(q[0]), 32'h81);

    // 4. Start from reset and hold both requests on both instances.
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      d_req[i] = 1; t_req[i] = 1; d_data[i] = 8'h3C; t_mask[i] = 8'hFF;
    end
    for (int n = 1; n <= 9; n++) begin
      tick();
      check($sformatf("rr0.dack[%0d]", n), 32'(d_ack[0]), 32'(e0_dack[n-1]));
      check($sformatf("rr0.tack[%0d]", n), 32'(t_ack[0]), 32'(e0_tack[n-1]));
      check($sformatf("rr1.dack[%0d]", n), 32'(d_ack[1]), 32'(e1_dack[n-1]));
      check($sformatf("rr1.tack[%0d]", n), 32'(t_ack[1]), 32'(e1_tack[n-1]));
      check($sformatf("rr1.busy[%0d]", n), 32'(busy[1]),  32'(e1_busy[n-1]));
      if (n == 2) check("rr0.q2", 32'(q[0]), 32'h3C);
      if (n == 4) check("rr0.q4", 32'(q[0]), 32'hC3);
      if (n == 6) check("rr0.q6", 32'(q[0]), 32'h3C);
      if (n == 6) check("rr1.q6", 32'(q[1]), 32'hC3);
    end
    for (int i = 0; i < 2; i++) begin d_req[i] = 0; t_req[i] = 0; end
    repeat (4) tick();

    // 5. Reset during SERVE_D with q=0x12 and d_data=0x55.
    d_req[0] = 1; d_data[0] = 8'h12;
    tick(); tick();
    check("pre.q", 32'(q[0]), 32'h12);
    d_data[0] = 8'h55;
    tick();
    check("srv.ack", 32'(d_ack[0]), 32'h1);
    reset = 1;
    tick();
    check("rsrv.q", 32'(q[0]), 32'h00);
    check("rsrv.ack", 32'(d_ack[0]), 32'h0);
    check("rsrv.busy", 32'(busy[0]), 32'h0);
    reset = 0; d_req[0] = 0;
    tick();
    check("rsrv.q_after", 32'(q[0]), 32'h00);

`ifdef FF_BANK_CLR_EN
    // 6. A clear and a load arrive together, and the clear goes first.
    d_req[0] = 1; d_data[0] = 8'h5A;
    tick(); tick();
    d_req[0] = 0;
    tick();
    check("clr.pre_q", 32'(q[0]), 32'h5A);
    clr_req[0] = 1; d_req[0] = 1; d_data[0] = 8'h77;
    tick();
    check("clr.ack", 32'(clr_ack[0]), 32'h1);
    check("clr.dack", 32'(d_ack[0]), 32'h0);
    tick();
    check("clr.q", 32'(q[0]), 32'h00);
    clr_req[0] = 0;
    tick();
    check("clr.then_dack", 32'(d_ack[0]), 32'h1);
    tick();
    check("clr.then_q", 32'(q[0]), 32'h77);
    d_req[0] = 0;
    tick();
`endif

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
